ls11_bist_ctrl: RTL and testbench

Built-in self-test sequencer for one SN74LS11 triple 3-input AND instance. On a start request it drives all 8 input combinations onto the three gates. Each gate gets a distinct pattern transform so that cross-wired inputs are detected. For each combination it waits a settle interval, samples the three outputs, and compares them against expected values. It reports pass/fail, a per-gate sticky fail mask and the first failing pattern. It sits between the board-level test logic and the SN74LS11 instance and owns all nine gate inputs.

---
 rtl/ls11_bist_pkg.sv | 23 ++
 rtl/ls11_pattern_gen.sv | 16 +
 rtl/ls11_bist_ctrl.sv | 106 ++++++++++
 tb/tb_ls11_bist_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ls11_bist_pkg.sv
// Shared types, sizes and golden-response helper for the SN74LS11 self-test.
package ls11_bist_pkg;

  localparam int unsigned NUM_PATTERNS = 8;
  localparam int unsigned NUM_GATES    = 3;
  localparam int unsigned PAT_W        = 3;
  localparam int unsigned DRV_W        = NUM_GATES * PAT_W;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Gate1 sees p, gate2 sees rotl(p) (same AND), gate3 sees ~p (AND is 1 only for p==0).
  function automatic logic [NUM_GATES-1:0] ls11_expected(input logic [PAT_W-1:0] p);
    return {(p == '0), &p, &p};
  endfunction

endpackage

// File: rtl/ls11_pattern_gen.sv
// Maps a pattern index to the nine gate inputs and the three expected gate outputs.
module ls11_pattern_gen
  import ls11_bist_pkg::*;
(
  input  logic [PAT_W-1:0]     p,
  output logic [DRV_W-1:0]     drv_c,
  output logic [NUM_GATES-1:0] exp_c
);

  // Distinct per-gate transforms so a cross-wired input shows up as a mismatch.
  always_comb begin
    drv_c = {~p, p[PAT_W-2:0], p[PAT_W-1], p};
    exp_c = ls11_expected(p);
  end

endmodule

// File: rtl/ls11_bist_ctrl.sv
// Self-test sequencer: walks 8 patterns through an SN74LS11 and records per-gate failures.
module ls11_bist_ctrl
  import ls11_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_start,
  input  logic [NUM_GATES-1:0] in_y,
  output logic [DRV_W-1:0]     out_drv,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_pass,
  output logic [NUM_GATES-1:0] out_fail_mask,
  output logic [PAT_W-1:0]     out_first_fail,
  output logic [PAT_W-1:0]     out_pattern
);

  localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS - 1);

  // Settle counter is CNT_W bits wide, so the interval must fit in 1..15.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("ls11_bist_ctrl: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  state_t               state;
  logic [CNT_W-1:0]     settle_cnt;
  logic [DRV_W-1:0]     pat_drv_c;
  logic [NUM_GATES-1:0] pat_exp_c;
  logic [NUM_GATES-1:0] mismatch_c;

  ls11_pattern_gen u_pattern_gen (
    .p     (out_pattern),
    .drv_c (pat_drv_c),
    .exp_c (pat_exp_c)
  );

  // Outputs are driven only from registered out_drv, so in_y is already settled and synchronous.
  assign mismatch_c = in_y ^ pat_exp_c;

  // Sequencer: state, settle counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      out_drv        <= '0;
      out_busy       <= 1'b0;
      out_done       <= 1'b0;
      out_pass       <= 1'b0;
      out_fail_mask  <= '0;
      out_first_fail <= '0;
      out_pattern    <= '0;
    end else begin
      out_done <= 1'b0;
      case (state)
        IDLE: begin
          out_drv <= '0;
          if (in_start) begin
            out_fail_mask  <= '0;
            out_first_fail <= '0;
            out_pass       <= 1'b0;
            out_pattern    <= '0;
            out_busy       <= 1'b1;
            state          <= APPLY;
          end
        end
        APPLY: begin
          out_drv    <= pat_drv_c;
          settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        CHECK: begin
          out_fail_mask <= out_fail_mask | mismatch_c;
          if (mismatch_c != '0 && out_fail_mask == '0) begin
            out_first_fail <= out_pattern;
          end
          if (out_pattern == LAST_PAT) begin
            out_busy <= 1'b0;
            state    <= DONE;
          end else begin
            out_pattern <= out_pattern + 1'b1;
            state       <= APPLY;
          end
        end
        DONE: begin
          out_done <= 1'b1;
          out_pass <= (out_fail_mask == '0);
          out_drv  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ls11_bist_ctrl.sv
// Self-checking bench for ls11_bist_ctrl with a faultable SN74LS11 model.
module tb_ls11_bist_ctrl;
  import ls11_bist_pkg::*;

  typedef struct {
    int         mode;    // 0 healthy, 1 gate2 SA1, 2 gate3 SA0, 3 gate1/gate2 A,B swapped
    int         glitch;  // relative edge at which to pulse in_start mid-run, 0 = none
    logic       pass;
    logic [2:0] mask;
    logic [2:0] first;
  } vec_t;

  typedef struct {
    logic       pass;
    logic [2:0] mask;
    logic [2:0] first;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [2:0] y0, y1;
  logic [8:0] drv0, drv1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] mask0, mask1, first0, first1, pat0, pat1;
  logic [2:0] pg_p;
  logic [8:0] pg_drv;
  logic [2:0] pg_exp;

  int mode  = 0;
  int cur   = 0;
  int ecnt  = 0;
  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  vec_t tbl[5];

  logic [8:0] m_drv;
  logic       m_busy, m_done, m_pass;
  logic [2:0] m_mask, m_first, m_pat;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  ls11_bist_ctrl #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_start(start0), .in_y(y0), .out_drv(drv0),
    .out_busy(busy0), .out_done(done0), .out_pass(pass0),
    .out_fail_mask(mask0), .out_first_fail(first0), .out_pattern(pat0)
  );

  ls11_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_start(start1), .in_y(y1), .out_drv(drv1),
    .out_busy(busy1), .out_done(done1), .out_pass(pass1),
    .out_fail_mask(mask1), .out_first_fail(first1), .out_pattern(pat1)
  );

  ls11_pattern_gen u_pg (.p(pg_p), .drv_c(pg_drv), .exp_c(pg_exp));

  assign m_drv   = (cur != 0) ? drv1   : drv0;
  assign m_busy  = (cur != 0) ? busy1  : busy0;
  assign m_done  = (cur != 0) ? done1  : done0;
  assign m_pass  = (cur != 0) ? pass1  : pass0;
  assign m_mask  = (cur != 0) ? mask1  : mask0;
  assign m_first = (cur != 0) ? first1 : first0;
  assign m_pat   = (cur != 0) ? pat1   : pat0;

  function automatic logic [8:0] tf(input logic [2:0] p);
    return {~p, p[1], p[0], p[2], p};
  endfunction

  function automatic logic [2:0] gold(input logic [2:0] p);
    return {(p == 3'd0), &p, &p};
  endfunction

  function automatic logic [2:0] chip(input logic [8:0] d, input int m);
    logic [2:0] g1, g2, g3, y;
    g1 = d[2:0];
    g2 = d[5:3];
    g3 = d[8:6];
    if (m == 3) begin
      g1 = {d[2], d[4], d[3]};
      g2 = {d[5], d[1], d[0]};
    end
    y = {&g3, &g2, &g1};
    if (m == 1) y[1] = 1'b1;
    if (m == 2) y[2] = 1'b0;
    return y;
  endfunction

  always_comb begin
    y0 = chip(drv0, mode);
    y1 = chip(drv1, mode);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One full run on the selected DUT; result is pushed to the scoreboard and popped at out_done.
  task automatic run(input int sel, input exp_t e, input int glitch);
    int   per, rel, e0, k;
    bit   seen;
    exp_t got;
    cur  = sel;
    per  = (sel != 0) ? 3 : 6;
    seen = 0;
    sb.push_back(e);
    @(negedge clk);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    e0 = ecnt;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      rel = ecnt - e0;
      if (glitch != 0 && rel == glitch) start0 = 1'b1;
      if (glitch != 0 && rel == glitch + 1) start0 = 1'b0;
      if (rel >= 1 && rel < 8 * per && ((rel - 1) % per) == 0) begin
        k = (rel - 1) / per;
        chk("drv_step", 32'(m_drv), 32'(tf(3'(k))));
        chk("pattern_idx", 32'(m_pat), 32'(k));
        chk("busy_mid", 32'(m_busy), 32'd1);
      end
      if (m_done) begin
        seen = 1;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          got = sb.pop_front();
          chk("done_edge", 32'(rel), 32'(got.lat));
          chk("pass", 32'(m_pass), 32'(got.pass));
          chk("fail_mask", 32'(m_mask), 32'(got.mask));
          chk("first_fail", 32'(m_first), 32'(got.first));
          chk("drv_idle", 32'(m_drv), 32'd0);
          chk("busy_done", 32'(m_busy), 32'd0);
        end
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    start0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   e0, d1, d2, rel;
    exp_t e;

    tbl[0] = '{mode: 0, glitch: 0,  pass: 1'b1, mask: 3'b000, first: 3'd0};
    tbl[1] = '{mode: 1, glitch: 0,  pass: 1'b0, mask: 3'b010, first: 3'd0};
    tbl[2] = '{mode: 2, glitch: 0,  pass: 1'b0, mask: 3'b100, first: 3'd0};
    tbl[3] = '{mode: 3, glitch: 0,  pass: 1'b0, mask: 3'b011, first: 3'd3};
    tbl[4] = '{mode: 0, glitch: 10, pass: 1'b1, mask: 3'b000, first: 3'd0};

    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    pg_p = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_drv", 32'(drv0), 32'd0);
    chk("rst_flags", 32'({busy0, done0, pass0}), 32'd0);
    chk("rst_results", 32'({mask0, first0, pat0}), 32'd0);
    chk("rst_dut1", 32'({drv1, busy1, done1, pass1, mask1, first1, pat1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int p = 0; p < 8; p++) begin
      pg_p = 3'(p);
      #1;
      chk("pg_drv", 32'(pg_drv), 32'(tf(3'(p))));
      chk("pg_exp", 32'(pg_exp), 32'(gold(3'(p))));
    end

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      e = '{pass: tbl[i].pass, mask: tbl[i].mask, first: tbl[i].first, lat: 49};
      run(0, e, tbl[i].glitch);
    end

    // Reset in SETTLE of pattern 3 with a failure already recorded.
    mode = 1;
    cur = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    e0 = ecnt;
    start0 = 1'b0;
    rel = 0;
    for (int i = 0; i < 40 && rel < 21; i++) begin
      @(negedge clk);
      rel = ecnt - e0;
    end
    chk("pre_rst_mask", 32'(mask0), 32'b010);
    chk("pre_rst_pat", 32'(pat0), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_drv", 32'(drv0), 32'd0);
    chk("mid_rst_all", 32'({busy0, done0, pass0, mask0, first0, pat0}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    run(0, '{pass: 1'b1, mask: 3'b000, first: 3'd0, lat: 49}, 0);

    // in_start held high: two back-to-back runs with one IDLE cycle between them.
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    e0 = ecnt;
    d1 = -1;
    d2 = -1;
    for (int i = 0; i < 150 && d2 < 0; i++) begin
      @(negedge clk);
      rel = ecnt - e0;
      if (done0 && d1 < 0) begin
        d1 = rel;
        chk("b2b_mask1", 32'(mask0), 32'b010);
      end else if (d1 >= 0 && rel == d1 + 1) begin
        chk("b2b_cleared", 32'({mask0, pass0, done0}), 32'd0);
        chk("b2b_busy", 32'(busy0), 32'd1);
      end else if (done0 && d1 >= 0) begin
        d2 = rel;
        start0 = 1'b0;
      end
    end
    chk("b2b_first_done", 32'(d1), 32'd49);
    chk("b2b_spacing", 32'(d2 - d1), 32'd50);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_no_restart", 32'(busy0), 32'd0);

    // Shortest settle interval on the second instance.
    mode = 0;
    run(1, '{pass: 1'b1, mask: 3'b000, first: 3'd0, lat: 25}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
